mem_loader: RTL

- Command sequencer between the Avalon register file (control_reg/data_reg writes, ready/answer reads) and the on-chip byte memory.
- Buffers host data words in a small FIFO and unpacks them into byte writes (LOAD).
- Reads back byte ranges and accumulates a 32-bit sum (SUM).
- Publishes status on ready and the result on answer, for the register file to return on reads of addresses 2 and 3.

---
 rtl/mem_loader.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : mem_loader
//  Purpose  : Command sequencer between the Avalon register file and an
//             on-chip byte memory. Host data words are buffered in a FIFO and
//             unpacked LSB-first into byte writes (LOAD); byte ranges are read
//             back and summed into a 32-bit result (SUM). Status is published
//             on ready, the result on answer.
//  Ports    : clk        - system clock
//             reset      - asynchronous active-low reset
//             cmd_valid  - control_reg write strobe, cmd_data = command word
//             wr_valid   - data_reg write strobe, wr_data = data word
//             mem_we/mem_addr/mem_wdata - byte write port to the memory
//             mem_rdata  - synchronous read data (one cycle after mem_addr)
//             ready      - {16'b0, fifo_count, 4'b0, cmd_err, overflow,
//                           busy, done}
//             answer     - SUM result (or LOAD checksum, see macro)
//  Options  : MEM_LOADER_CKSUM_EN - when defined, LOAD clears answer at
//             acceptance and accumulates the sum of every byte written.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_loader #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [31:0]       cmd_data,
  input  logic              wr_valid,
  input  logic [31:0]       wr_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       ready,
  output logic [31:0]       answer
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [9:0]        LEN_ONE  = 10'd1;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SUM   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SUM_RD    = 3'd2,
    S_SUM_FLUSH = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t state;

  // FIFO storage and control
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_cnt;

  // Sequencer registers
  logic [31:0]       cur_word;    // remaining bytes of the word being unpacked
  logic [1:0]        byte_left;   // bytes still valid in cur_word
  logic [9:0]        len_left;    // bytes still to write / addresses to issue
  logic [ADDR_W-1:0] wr_addr;     // next LOAD byte address
  logic              rd_pending;  // a read address was issued last cycle
  logic              done;
  logic              overflow;
  logic              cmd_err;

  // Command decode
  logic [1:0]        cmd_op;
  logic [9:0]        cmd_len;
  logic [ADDR_W-1:0] cmd_base;
  logic              unused_cmd_bits;

  logic              fifo_empty;
  logic              fifo_full;
  logic [31:0]       fifo_head;
  logic              busy;
  logic              idle_like;
  logic              do_clear;
  logic              pop;
  logic              push;
  logic              drop;
  logic              emit;
  logic [7:0]        emit_byte;
  logic [7:0]        cnt8;

  assign cmd_op          = cmd_data[31:30];
  assign cmd_len         = cmd_data[19:10];
  assign cmd_base        = cmd_data[ADDR_W-1:0];
  assign unused_cmd_bits = ^cmd_data[29:20];

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_head  = fifo_mem[rd_ptr];

  assign busy      = (state == S_LOAD) || (state == S_SUM_RD) || (state == S_SUM_FLUSH);
  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign do_clear  = cmd_valid && idle_like && (cmd_op == OP_CLEAR);

  // A byte is emitted whenever LOAD still owes bytes and one is at hand,
  // either left over in cur_word or at the FIFO head (which is then popped).
  assign emit      = (state == S_LOAD) && (len_left != '0) &&
                     ((byte_left != 2'd0) || !fifo_empty);
  assign pop       = emit && (byte_left == 2'd0);
  assign emit_byte = (byte_left != 2'd0) ? cur_word[7:0] : fifo_head[7:0];

  // A pop in the same cycle frees a slot, so a push while full is accepted.
  assign push = wr_valid && (!fifo_full || pop) && !do_clear;
  assign drop = wr_valid && fifo_full && !pop;

  assign cnt8  = 8'(fifo_cnt);
  assign ready = {16'b0, cnt8, 4'b0, cmd_err, overflow, busy, done};

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (do_clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset; contents are only visible through fifo_cnt.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_data;
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      answer     <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      cmd_err    <= 1'b0;
      cur_word   <= '0;
      byte_left  <= 2'd0;
      len_left   <= '0;
      wr_addr    <= '0;
      rd_pending <= 1'b0;
    end else begin
      mem_we <= 1'b0;

      if (drop)              overflow <= 1'b1;
      if (cmd_valid && busy) cmd_err  <= 1'b1;

      // Read data for last cycle's address arrives now.
      if (rd_pending) answer <= answer + {24'b0, mem_rdata};

      case (state)
        S_IDLE, S_DONE: begin
          if (cmd_valid) begin
            done <= 1'b0;
            case (cmd_op)
              OP_CLEAR: begin
                state    <= S_IDLE;
                overflow <= 1'b0;
                cmd_err  <= 1'b0;
                answer   <= '0;
              end
              OP_LOAD: begin
`ifdef MEM_LOADER_CKSUM_EN
                answer <= '0;
`endif
                wr_addr   <= cmd_base;
                len_left  <= cmd_len;
                byte_left <= 2'd0;
                if (cmd_len == '0) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end else begin
                  state <= S_LOAD;
                end
              end
              OP_SUM: begin
                answer     <= '0;
                mem_addr   <= cmd_base;
                len_left   <= cmd_len;
                rd_pending <= 1'b0;
                if (cmd_len == '0) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end else begin
                  state <= S_SUM_RD;
                end
              end
              default: begin  // OP_NOP
                state <= S_DONE;
                done  <= 1'b1;
              end
            endcase
          end
        end

        S_LOAD: begin
          if (len_left == '0) begin
            // Any bytes left in cur_word are discarded with the word.
            state     <= S_DONE;
            done      <= 1'b1;
            byte_left <= 2'd0;
          end else if (emit) begin
            mem_we    <= 1'b1;
            mem_wdata <= emit_byte;
            mem_addr  <= wr_addr;
            wr_addr   <= wr_addr + ADDR_ONE;
            len_left  <= len_left - LEN_ONE;
            if (byte_left != 2'd0) begin
              cur_word  <= cur_word >> 8;
              byte_left <= byte_left - 2'd1;
            end else begin
              cur_word  <= fifo_head >> 8;
              byte_left <= 2'd3;
            end
`ifdef MEM_LOADER_CKSUM_EN
            answer <= answer + {24'b0, emit_byte};
`endif
          end
          // else: FIFO empty at a word boundary, stall with address held
        end

        S_SUM_RD: begin
          rd_pending <= 1'b1;
          len_left   <= len_left - LEN_ONE;
          if (len_left == LEN_ONE) begin
            state <= S_SUM_FLUSH;
          end else begin
            mem_addr <= mem_addr + ADDR_ONE;
          end
        end

        S_SUM_FLUSH: begin
          // The final byte is absorbed by the rd_pending add above.
          rd_pending <= 1'b0;
          state      <= S_DONE;
          done       <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
